// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Microcoded control unit. Holds the instruction register,
//               T-state counter, ALU flag register and sticky halt, and
//               decodes every datapath control line from them.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int unsigned EARLY_END = 1
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] bus,
    input  logic       zf,
    input  logic       cf,
    output logic       co,
    output logic       ce,
    output logic       j,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       bi,
    output logic       eo,
    output logic       su,
    output logic       oi,
    output logic       halt,
    output logic       zf_q,
    output logic       cf_q,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    tstate_e    step_q;
    tstate_e    step_d;
    logic [7:0] ir_q;
    logic       halt_q;
    logic [3:0] op;
    logic       io;         // drive IR operand nibble onto the bus
    logic       fi;         // capture ALU flags at the end of this step
    logic       last_step;  // this step is the final one the opcode uses
    logic       hlt_set;

    assign op      = ir_q[7:4];
    assign step    = step_q;
    assign halt    = halt_q;
    assign hlt_set = !rst && !halt_q && (step_q == T2) && (op == OP_HLT);

    // Operand nibble goes out only while the decode asks for it; reset forces z
    assign bus = io ? {4'h0, ir_q[3:0]} : 8'hzz;

    // Control decode; reset and halt silence every line
    always_comb begin
        co = 1'b0; ce = 1'b0; j  = 1'b0; mi = 1'b0; ri = 1'b0;
        ro = 1'b0; ii = 1'b0; ai = 1'b0; ao = 1'b0; bi = 1'b0;
        eo = 1'b0; su = 1'b0; oi = 1'b0; io = 1'b0; fi = 1'b0;
        if (!rst && !halt_q) begin
            case (step_q)
                T0: begin co = 1'b1; mi = 1'b1; end
                T1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
                        OP_LDI: begin io = 1'b1; ai = 1'b1; end
                        OP_JMP: begin io = 1'b1; j  = 1'b1; end
                        OP_JC:  begin io = cf_q; j = cf_q; end
                        OP_JZ:  begin io = zf_q; j = zf_q; end
                        OP_OUT: begin ao = 1'b1; oi = 1'b1; end
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin ro = 1'b1; ai = 1'b1; end
                        OP_ADD: begin ro = 1'b1; bi = 1'b1; end
                        // su asserted early so the ALU result is a difference when B loads
                        OP_SUB: begin ro = 1'b1; bi = 1'b1; su = 1'b1; end
                        OP_STA: begin ao = 1'b1; ri = 1'b1; end
                        default: ;
                    endcase
                end
                T4: begin
                    case (op)
                        OP_ADD: begin eo = 1'b1; ai = 1'b1; fi = 1'b1; end
                        OP_SUB: begin eo = 1'b1; ai = 1'b1; su = 1'b1; fi = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Final used step per opcode, for early return to T0
    always_comb begin
        case (op)
            OP_LDA, OP_STA: last_step = (step_q == T3);
            OP_ADD, OP_SUB: last_step = (step_q == T4);
            default:        last_step = (step_q == T2);
        endcase
    end

    // Next T-state: advance, wrap after T4, or return early; halting parks at T0
    always_comb begin
        case (step_q)
            T0:      step_d = T1;
            T1:      step_d = T2;
            T2:      step_d = T3;
            T3:      step_d = T4;
            default: step_d = T0;
        endcase
        if ((EARLY_END != 0) && last_step) begin
            step_d = T0;
        end
        if (hlt_set) begin
            step_d = T0;
        end
    end

    // State registers: step, IR, flags and halt; halt freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= T0;
            ir_q   <= 8'h00;
            zf_q   <= 1'b0;
            cf_q   <= 1'b0;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            step_q <= step_d;
            if (step_q == T1) begin
                ir_q <= bus;
            end
            if (fi) begin
                zf_q <= zf;
                cf_q <= cf;
            end
            if (hlt_set) begin
                halt_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. Two instances
//               (EARLY_END=0 and EARLY_END=1) share stimulus and are checked
//               every cycle against a table-driven microcode model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam logic [13:0] M_IO = 14'h2000;
    localparam logic [13:0] M_CO = 14'h1000;
    localparam logic [13:0] M_CE = 14'h0800;
    localparam logic [13:0] M_J  = 14'h0400;
    localparam logic [13:0] M_MI = 14'h0200;
    localparam logic [13:0] M_RI = 14'h0100;
    localparam logic [13:0] M_RO = 14'h0080;
    localparam logic [13:0] M_II = 14'h0040;
    localparam logic [13:0] M_AI = 14'h0020;
    localparam logic [13:0] M_AO = 14'h0010;
    localparam logic [13:0] M_BI = 14'h0008;
    localparam logic [13:0] M_EO = 14'h0004;
    localparam logic [13:0] M_SU = 14'h0002;
    localparam logic [13:0] M_OI = 14'h0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       zf;
    logic       cf;
    logic [7:0] drive_byte;
    logic       drv0;
    logic       drv1;
    wire  [7:0] bus0;
    wire  [7:0] bus1;
    wire  [1:0] co, ce, j, mi, ri, ro, ii, ai, ao, bi, eo, su, oi, halt, zfq, cfq;
    wire  [2:0] step0;
    wire  [2:0] step1;

    int checks = 0;
    int errors = 0;

    // Microcode table and per-opcode length
    logic [13:0] uc [16][5];
    int          len_t [16];

    // Reference model state, index = EARLY_END value of the instance
    int         m_step [2];
    logic [7:0] m_ir   [2];
    logic       m_zf   [2];
    logic       m_cf   [2];
    logic       m_halt [2];
    logic       m_valid = 1'b0;

    always #5 clk = ~clk;

    assign bus0 = drv0 ? drive_byte : 8'hzz;
    assign bus1 = drv1 ? drive_byte : 8'hzz;

    control_sequencer #(.EARLY_END(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .zf(zf), .cf(cf),
        .co(co[0]), .ce(ce[0]), .j(j[0]), .mi(mi[0]), .ri(ri[0]), .ro(ro[0]),
        .ii(ii[0]), .ai(ai[0]), .ao(ao[0]), .bi(bi[0]), .eo(eo[0]), .su(su[0]),
        .oi(oi[0]), .halt(halt[0]), .zf_q(zfq[0]), .cf_q(cfq[0]), .step(step0)
    );

    control_sequencer #(.EARLY_END(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .zf(zf), .cf(cf),
        .co(co[1]), .ce(ce[1]), .j(j[1]), .mi(mi[1]), .ri(ri[1]), .ro(ro[1]),
        .ii(ii[1]), .ai(ai[1]), .ao(ao[1]), .bi(bi[1]), .eo(eo[1]), .su(su[1]),
        .oi(oi[1]), .halt(halt[1]), .zf_q(zfq[1]), .cf_q(cfq[1]), .step(step1)
    );

    task automatic init_tables();
        for (int op = 0; op < 16; op++) begin
            uc[op][0] = M_CO | M_MI;
            uc[op][1] = M_RO | M_II | M_CE;
            uc[op][2] = '0;
            uc[op][3] = '0;
            uc[op][4] = '0;
            len_t[op] = 3;
        end
        uc[1][2] = M_IO | M_MI; uc[1][3] = M_RO | M_AI; len_t[1] = 4;
        uc[2][2] = M_IO | M_MI; uc[2][3] = M_RO | M_BI; uc[2][4] = M_EO | M_AI; len_t[2] = 5;
        uc[3][2] = M_IO | M_MI; uc[3][3] = M_RO | M_BI | M_SU;
        uc[3][4] = M_EO | M_AI | M_SU; len_t[3] = 5;
        uc[4][2] = M_IO | M_MI; uc[4][3] = M_AO | M_RI; len_t[4] = 4;
        uc[5][2] = M_IO | M_AI;
        uc[6][2] = M_IO | M_J;
        uc[7][2] = M_IO | M_J;
        uc[8][2] = M_IO | M_J;
        uc[14][2] = M_AO | M_OI;
        for (int e = 0; e < 2; e++) begin
            m_step[e] = 0; m_ir[e] = '0; m_zf[e] = 1'b0; m_cf[e] = 1'b0; m_halt[e] = 1'b0;
        end
    endtask

    function automatic logic [13:0] exp_ctl(input int e);
        logic [3:0]  op;
        logic [13:0] v;
        if (rst || m_halt[e]) return '0;
        op = m_ir[e][7:4];
        v  = uc[op][m_step[e]];
        if (m_step[e] == 2 && ((op == 4'h7 && !m_cf[e]) || (op == 4'h8 && !m_zf[e])))
            v = '0;
        return v;
    endfunction

    task automatic chk(input string tag, input int e, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, e, obs, exp);
        end
    endtask

    // Bench drives the bus whenever the model says the DUT should not
    task automatic refresh();
        logic [13:0] v;
        v = exp_ctl(0); drv0 = !v[13];
        v = exp_ctl(1); drv1 = !v[13];
    endtask

    task automatic check(input int e);
        logic [13:0] v;
        logic [12:0] obs;
        logic [7:0]  ebus;
        v    = exp_ctl(e);
        obs  = {co[e], ce[e], j[e], mi[e], ri[e], ro[e], ii[e], ai[e], ao[e],
                bi[e], eo[e], su[e], oi[e]};
        ebus = v[13] ? {4'h0, m_ir[e][3:0]} : drive_byte;
        chk("ctl", e, 16'(obs), 16'(v[12:0]));
        chk("bus", e, 16'(e ? bus1 : bus0), 16'(ebus));
        if (m_valid) begin
            chk("step", e, 16'(e ? step1 : step0), 16'(m_step[e]));
            chk("halt", e, 16'(halt[e]), 16'(m_halt[e]));
            chk("zf_q", e, 16'(zfq[e]), 16'(m_zf[e]));
            chk("cf_q", e, 16'(cfq[e]), 16'(m_cf[e]));
        end
    endtask

    task automatic update(input int e);
        logic [3:0] op;
        int         t;
        int         nxt;
        if (rst) begin
            m_step[e] = 0; m_ir[e] = '0; m_zf[e] = 1'b0; m_cf[e] = 1'b0; m_halt[e] = 1'b0;
            m_valid   = 1'b1;
        end else if (!m_halt[e]) begin
            op = m_ir[e][7:4];
            t  = m_step[e];
            if (t == 1) m_ir[e] = drive_byte;
            if (t == 4 && (op == 4'h2 || op == 4'h3)) begin
                m_zf[e] = zf; m_cf[e] = cf;
            end
            if (e == 1) nxt = (t >= len_t[op] - 1) ? 0 : t + 1;
            else        nxt = (t + 1) % 5;
            if (t == 2 && op == 4'hF) begin
                m_halt[e] = 1'b1; nxt = 0;
            end
            m_step[e] = nxt;
        end
    endtask

    // One clock cycle: check current state, advance model, settle on new state
    task automatic cyc();
        refresh();
        #1;
        check(0);
        check(1);
        @(posedge clk);
        update(0);
        update(1);
        @(negedge clk);
        refresh();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        refresh();
        #1;
    endtask

    initial begin
        logic [3:0] op;
        init_tables();
        rst = 1'b1; zf = 1'b0; cf = 1'b0; drive_byte = 8'h00;
        drv0 = 1'b1; drv1 = 1'b1;

        // Reset held two cycles
        cyc();
        cyc();
        chk("rst_co", 1, 16'(co[1]), 16'h0);
        chk("rst_mi", 1, 16'(mi[1]), 16'h0);
        rst = 1'b0;
        refresh();
        #1;
        chk("rel_step", 1, 16'(step1), 16'h0);
        chk("rel_co", 1, 16'(co[1]), 16'h1);
        chk("rel_mi", 1, 16'(mi[1]), 16'h1);

        // LDI 7
        drive_byte = 8'h57;
        cyc(); cyc();
        chk("ldi_bus", 1, 16'(bus1), 16'h0007);
        chk("ldi_ai", 1, 16'(ai[1]), 16'h1);
        cyc();
        chk("ldi_end", 1, 16'(step1), 16'h0);

        // ADD with zf=0, cf=1
        do_reset();
        drive_byte = 8'h23; zf = 1'b0; cf = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("add_eo", 1, 16'(eo[1]), 16'h1);
        chk("add_ai", 1, 16'(ai[1]), 16'h1);
        chk("add_su", 1, 16'(su[1]), 16'h0);
        cyc();
        chk("add_cf", 1, 16'(cfq[1]), 16'h1);
        chk("add_zf", 1, 16'(zfq[1]), 16'h0);

        // JC 9 taken, then not taken after reset clears cf_q
        drive_byte = 8'h79; cf = 1'b0;
        cyc(); cyc();
        chk("jc_j", 1, 16'(j[1]), 16'h1);
        chk("jc_bus", 1, 16'(bus1), 16'h0009);
        cyc();
        do_reset();
        cyc(); cyc();
        chk("jnc_j", 1, 16'(j[1]), 16'h0);
        chk("jnc_bus", 1, 16'(bus1), 16'h0079);

        // HLT
        do_reset();
        drive_byte = 8'hF0;
        cyc(); cyc(); cyc();
        chk("hlt_halt", 1, 16'(halt[1]), 16'h1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("hlt_ctl", 1, 16'({co[1], ce[1], j[1], mi[1], ri[1], ro[1], ii[1], ai[1],
                                  ao[1], bi[1], eo[1], su[1], oi[1]}), 16'h0);
        end
        do_reset();
        chk("hlt_clr", 1, 16'(halt[1]), 16'h0);

        // Set both flags, then abort SUB at T3
        drive_byte = 8'h20; zf = 1'b1; cf = 1'b1;
        cyc(); cyc(); cyc(); cyc(); cyc();
        drive_byte = 8'h35; zf = 1'b0; cf = 1'b0;
        cyc(); cyc(); cyc();
        chk("sub_t3_su", 1, 16'(su[1]), 16'h1);
        do_reset();
        chk("abort_step", 1, 16'(step1), 16'h0);
        chk("abort_su", 1, 16'(su[1]), 16'h0);
        chk("abort_zf", 1, 16'(zfq[1]), 16'h0);
        chk("abort_cf", 1, 16'(cfq[1]), 16'h0);

        // NOP length: 5 cycles without early end, 3 with
        drive_byte = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("nop_step", 0, 16'(step0), 16'(i % 5));
            chk("nop_step", 1, 16'(step1), 16'(i % 3));
            cyc();
        end

        // Randomised programs with occasional reset and halt
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            zf  = 1'($urandom_range(0, 1));
            cf  = 1'($urandom_range(0, 1));
            op  = ($urandom_range(0, 29) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            drive_byte = {op, 4'($urandom_range(0, 15))};
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
